// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer
// N-channel glitch filter for slow digital inputs. Each channel passes through a
// two-flop synchroniser and then a consecutive-mismatch run counter: the filtered
// level only flips after the effective threshold of back-to-back enabled samples
// disagree with it. Rise/fall strobes and a sticky glitch flag (set when a
// mismatch run is abandoned before reaching the threshold) are produced per channel.
module multi_channel_debouncer #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                sample_clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CNT_W-1:0]    threshold,
  input  logic [CHANNELS-1:0] clear_glitch,
  output logic [CHANNELS-1:0] filtered_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] glitch_flag
);

  // A threshold of zero behaves like one; widened by a bit so the run
  // comparison below can never wrap.
  function automatic logic [CNT_W:0] eff_thresh(input logic [CNT_W-1:0] t);
    return (t == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, t};
  endfunction

  logic [CHANNELS-1:0] sync_p0;
  logic [CHANNELS-1:0] sync_p1;
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] filt_nxt;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;
  logic [CHANNELS-1:0] glitch_nxt;
  logic [CNT_W:0]      t_eff;

  assign t_eff = eff_thresh(threshold);

  // Stage p0 -> p1: two-flop synchroniser, free-running regardless of sample_en.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= {CHANNELS{RESET_LEVEL}};
      sync_p1 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Per-channel run counter decision: flip, extend the run, abort it, or hold.
  always_comb begin
    logic [CNT_W:0] cnt_inc;
    cnt_inc    = '0;
    filt_nxt   = filtered_out;
    rise_nxt   = '0;
    fall_nxt   = '0;
    glitch_nxt = glitch_flag;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cnt_nxt[ch] = cnt_q[ch];
      cnt_inc     = {1'b0, cnt_q[ch]} + {{CNT_W{1'b0}}, 1'b1};
      if (sample_en) begin
        // An abort below overrides this clear (set wins over clear).
        glitch_nxt[ch] = glitch_flag[ch] & ~clear_glitch[ch];
        if (sync_p1[ch] != filtered_out[ch]) begin
          if (cnt_inc >= t_eff) begin
            // ">=" so a threshold lowered under a running count flips at once.
            cnt_nxt[ch]  = '0;
            filt_nxt[ch] = sync_p1[ch];
            rise_nxt[ch] = sync_p1[ch];
            fall_nxt[ch] = ~sync_p1[ch];
          end else begin
            cnt_nxt[ch] = cnt_inc[CNT_W-1:0];
          end
        end else if (cnt_q[ch] != '0) begin
          cnt_nxt[ch]    = '0;
          glitch_nxt[ch] = 1'b1;
        end
      end
    end
  end

  // Stage p1 -> outputs: register filtered levels, strobes, glitch flags and counters.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered_out <= {CHANNELS{RESET_LEVEL}};
      rise_pulse   <= '0;
      fall_pulse   <= '0;
      glitch_flag  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      filtered_out <= filt_nxt;
      rise_pulse   <= rise_nxt;
      fall_pulse   <= fall_nxt;
      glitch_flag  <= glitch_nxt;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_nxt[ch];
      end
    end
  end

endmodule
